orlink: RTL and testbench

ORLINK -- requirements
Module: orlink

---
 rtl/orlink_pkg.sv | 27 ++
 rtl/orlink_regfile.sv | 45 ++++
 rtl/orlink.sv | 145 ++++++++++++++
 tb/tb_orlink.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/orlink_pkg.sv
// Shared types and constants for the orlink FX2 host-link engine.
package orlink_pkg;

    localparam int CNT_W  = 32;
    localparam int DATA_W = 8;

    localparam logic [1:0] FIFO_OUT = 2'b00;
    localparam logic [1:0] FIFO_IN  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CNT0,
        ST_CNT1,
        ST_CNT2,
        ST_CNT3,
        ST_H2F,
        ST_F2H,
        ST_PKTEND
    } state_t;

    // Count bytes arrive MSB first, so each new byte enters at the bottom.
    function automatic logic [CNT_W-1:0] shift_cnt(input logic [CNT_W-1:0] cnt,
                                                   input logic [DATA_W-1:0] b);
        return {cnt[CNT_W-DATA_W-1:0], b};
    endfunction

endpackage

// File: rtl/orlink_regfile.sv
// Channel register bank: one 8-bit register per channel, synchronous write,
// combinational read; addresses beyond NUM_REGS read as zero and ignore writes.
module orlink_regfile
    import orlink_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 7
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [DATA_W-1:0] w_bank [NUM_REGS];
    logic              w_in_range;
    logic [IDX_W-1:0]  w_idx;

    // Full-width compare so that e.g. channel 0x40 never aliases channel 0.
    assign w_in_range = (int'(i_addr) < NUM_REGS);
    assign w_idx      = i_addr[IDX_W-1:0];
    assign o_rdata    = w_in_range ? w_bank[w_idx] : '0;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [DATA_W-1:0] r_val;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_val <= '0;
                end else if (i_we && w_in_range && (w_idx == IDX_W'(gi))) begin
                    r_val <= i_wdata;
                end
            end

            assign w_bank[gi] = r_val;
        end
    endgenerate

endmodule

// File: rtl/orlink.sv
// FX2 slave-FIFO link: parses host frames (dir/channel, 32-bit count, data)
// into channel register writes and reads. Define ORLINK_PKTEND_EN for a packet commit.
module orlink
    import orlink_pkg::*;
#(
    parameter int NUM_REGS = 16
) (
    input  logic       ifclk_in,
    input  logic       wb_rst,
    input  logic       wb_clk,
    inout  wire  [7:0] fifoData_io,
    input  logic       gotData_in,
    input  logic       gotRoom_in,
    output logic       sloe_out,
    output logic       slrd_out,
    output logic       slwr_out,
    output logic [1:0] fifoAddr_out,
    output logic       pktEnd_out
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t             r_state, w_state_next;
    logic [CNT_W-1:0]   r_count, w_count_next;
    logic               r_dir, w_dir_next;
    logic [6:0]         r_chan, w_chan_next;
    logic               w_consume;
    logic               w_we;
    logic               w_drive;
    logic [DATA_W-1:0]  w_rd_byte;
    logic [DATA_W-1:0]  w_rdata;
    logic [CNT_W-1:0]   w_count_full;
    logic               w_unused_wb_clk;

    assign w_unused_wb_clk = wb_clk;
    assign w_rd_byte       = fifoData_io;
    assign fifoData_io     = w_drive ? w_rdata : 8'hzz;
    assign w_consume       = ~slrd_out & gotData_in;
    assign w_count_full    = shift_cnt(r_count, w_rd_byte);

    orlink_regfile #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (7)
    ) u_regfile (
        .i_clk    (ifclk_in),
        .i_rst    (wb_rst),
        .i_we     (w_we),
        .i_addr   (r_chan),
        .i_wdata  (w_rd_byte),
        .o_rdata  (w_rdata)
    );

    always_ff @(posedge ifclk_in or posedge wb_rst) begin
        if (wb_rst) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_dir   <= 1'b0;
            r_chan  <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_dir   <= w_dir_next;
            r_chan  <= w_chan_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_dir_next   = r_dir;
        w_chan_next  = r_chan;
        w_we         = 1'b0;
        case (r_state)
            ST_IDLE: if (w_consume) begin
                w_dir_next   = w_rd_byte[7];
                w_chan_next  = w_rd_byte[6:0];
                w_count_next = '0;
                w_state_next = ST_CNT0;
            end
            ST_CNT0: if (w_consume) begin
                w_count_next = w_count_full;
                w_state_next = ST_CNT1;
            end
            ST_CNT1: if (w_consume) begin
                w_count_next = w_count_full;
                w_state_next = ST_CNT2;
            end
            ST_CNT2: if (w_consume) begin
                w_count_next = w_count_full;
                w_state_next = ST_CNT3;
            end
            ST_CNT3: if (w_consume) begin
                w_count_next = w_count_full;
                if (w_count_full == '0)
                    w_state_next = ST_IDLE;
                else
                    w_state_next = r_dir ? ST_F2H : ST_H2F;
            end
            ST_H2F: if (w_consume) begin
                w_we         = 1'b1;
                w_count_next = r_count - CNT_ONE;
                if (r_count == CNT_ONE)
                    w_state_next = ST_IDLE;
            end
            ST_F2H: if (gotRoom_in) begin
                w_count_next = r_count - CNT_ONE;
                if (r_count == CNT_ONE)
`ifdef ORLINK_PKTEND_EN
                    w_state_next = ST_PKTEND;
`else
                    w_state_next = ST_IDLE;
`endif
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        sloe_out     = 1'b0;
        slrd_out     = 1'b0;
        slwr_out     = 1'b1;
        fifoAddr_out = FIFO_OUT;
        pktEnd_out   = 1'b1;
        w_drive      = 1'b0;
        case (r_state)
            ST_F2H: begin
                sloe_out     = 1'b1;
                slrd_out     = 1'b1;
                slwr_out     = ~gotRoom_in;
                fifoAddr_out = FIFO_IN;
                w_drive      = 1'b1;
            end
`ifdef ORLINK_PKTEND_EN
            ST_PKTEND: begin
                sloe_out     = 1'b1;
                slrd_out     = 1'b1;
                fifoAddr_out = FIFO_IN;
                pktEnd_out   = 1'b0;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_orlink.sv
// Scoreboard bench for orlink: read frames push expected bytes, the strobe
// monitor pops and compares them.
`timescale 1ns/1ps
module tb_orlink;

    logic       ifclk_in   = 1'b0;
    logic       wb_clk     = 1'b0;
    logic       wb_rst     = 1'b1;
    logic       gotData_in = 1'b0;
    logic       gotRoom_in = 1'b1;
    logic [7:0] host_byte  = 8'h00;
    wire  [7:0] fifoData_io;
    logic       sloe_out, slrd_out, slwr_out, pktEnd_out;
    logic [1:0] fifoAddr_out;

    int         n_checks   = 0;
    int         n_pass     = 0;
    int         strobe_cnt = 0;
    int         pkt_cnt    = 0;
    logic [7:0] exp_q [$];

`ifdef ORLINK_PKTEND_EN
    localparam int PKT_EXP = 1;
`else
    localparam int PKT_EXP = 0;
`endif

    always #5 ifclk_in = ~ifclk_in;
    always #7 wb_clk   = ~wb_clk;

    // Host side drives the bus whenever the FPGA enables FX2 output.
    assign fifoData_io = (sloe_out == 1'b0) ? host_byte : 8'hzz;

    orlink #(.NUM_REGS(16)) dut (
        .ifclk_in     (ifclk_in),
        .wb_rst       (wb_rst),
        .wb_clk       (wb_clk),
        .fifoData_io  (fifoData_io),
        .gotData_in   (gotData_in),
        .gotRoom_in   (gotRoom_in),
        .sloe_out     (sloe_out),
        .slrd_out     (slrd_out),
        .slwr_out     (slwr_out),
        .fifoAddr_out (fifoAddr_out),
        .pktEnd_out   (pktEnd_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    // Strobe/commit monitor, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge ifclk_in);
            if (wb_rst === 1'b0 && slwr_out === 1'b0) begin
                strobe_cnt++;
                chk("strobe_expected", {31'b0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) chk("rd_data", {24'b0, fifoData_io}, {24'b0, exp_q.pop_front()});
            end
            if (wb_rst === 1'b0 && pktEnd_out === 1'b0) begin
                pkt_cnt++;
                chk("pkt_addr", {30'b0, fifoAddr_out}, 32'd2);
                chk("pkt_slwr", {31'b0, slwr_out}, 32'd1);
            end
        end
    end

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_sloe"},   {31'b0, sloe_out},     32'd0);
        chk({tag, "_slrd"},   {31'b0, slrd_out},     32'd0);
        chk({tag, "_slwr"},   {31'b0, slwr_out},     32'd1);
        chk({tag, "_addr"},   {30'b0, fifoAddr_out}, 32'd0);
        chk({tag, "_pktend"}, {31'b0, pktEnd_out},   32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        k          = 0;
        host_byte  = b;
        gotData_in = 1'b1;
        do begin
            @(negedge ifclk_in);
            k++;
        end while (slrd_out !== 1'b0 && k < 200);
        chk("consume_timeout", {31'b0, k >= 200}, 32'd0);
        @(posedge ifclk_in);
        #1;
        gotData_in = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge ifclk_in);
        #1;
    endtask

    task automatic send_hdr(input logic dir, input logic [6:0] ch, input logic [31:0] n, input int gap);
        send_byte({dir, ch});
        idle_cycles(gap);
        for (int i = 3; i >= 0; i--) begin
            send_byte(n[8*i +: 8]);
            if (i != 0) idle_cycles(gap);
        end
    endtask

    task automatic write_frame(input logic [6:0] ch, input int n, input logic [31:0] data, input int gap);
        $display("txn write ch=%02h n=%0d data=%0h", ch, n, data);
        send_hdr(1'b0, ch, n, gap);
        for (int i = n - 1; i >= 0; i--) send_byte(data[8*i +: 8]);
    endtask

    task automatic start_read(input logic [6:0] ch, input int n, input logic [7:0] exp);
        $display("txn read  ch=%02h n=%0d expect=%02h", ch, n, exp);
        strobe_cnt = 0;
        pkt_cnt    = 0;
        for (int i = 0; i < n; i++) exp_q.push_back(exp);
        send_hdr(1'b1, ch, n, 0);
    endtask

    task automatic finish_read(input int n);
        int k;
        k = 0;
        while (sloe_out !== 1'b0 && k < 500) begin
            @(posedge ifclk_in);
            #1;
            k++;
        end
        chk("rd_timeout", {31'b0, k >= 500}, 32'd0);
        chk("strobe_count", strobe_cnt, n);
        chk("queue_drained", exp_q.size(), 32'd0);
        chk("pktend_pulses", pkt_cnt, (n == 0) ? 0 : PKT_EXP);
    endtask

    task automatic do_read(input logic [6:0] ch, input int n, input logic [7:0] exp);
        start_read(ch, n, exp);
        finish_read(n);
    endtask

    initial begin
        repeat (3) @(posedge ifclk_in);
        #1;
        chk_idle_outputs("reset");
        wb_rst = 1'b0;
        idle_cycles(1);

        do_read(7'h05, 3, 8'h00);
        write_frame(7'h00, 1, 32'h13, 0);
        do_read(7'h00, 1, 8'h13);
        write_frame(7'h01, 3, 32'hAABBCC, 0);
        do_read(7'h01, 2, 8'hCC);
        write_frame(7'h40, 1, 32'h55, 0);
        do_read(7'h40, 1, 8'h00);
        do_read(7'h00, 1, 8'h13);
        do_read(7'h01, 0, 8'h00);

        // Back-pressure: gotRoom_in low for two edges after the second byte.
        start_read(7'h01, 4, 8'hCC);
        for (int k = 0; k < 200 && strobe_cnt < 2; k++) begin
            @(posedge ifclk_in);
            #1;
        end
        gotRoom_in = 1'b0;
        repeat (2) begin
            @(negedge ifclk_in);
            chk("stall_slwr", {31'b0, slwr_out}, 32'd1);
            chk("stall_sloe", {31'b0, sloe_out}, 32'd1);
        end
        @(posedge ifclk_in);
        #1;
        gotRoom_in = 1'b1;
        finish_read(4);

        // Gaps in gotData_in between header bytes.
        write_frame(7'h02, 2, 32'h5A6B, 3);
        do_read(7'h02, 1, 8'h6B);

        // Asynchronous reset while stalled in the read phase.
        $display("txn reset during read");
        gotRoom_in = 1'b0;
        strobe_cnt = 0;
        send_hdr(1'b1, 7'h01, 32'd5, 0);
        @(negedge ifclk_in);
        chk("f2h_sloe", {31'b0, sloe_out}, 32'd1);
        chk("f2h_addr", {30'b0, fifoAddr_out}, 32'd2);
        #3;
        wb_rst = 1'b1;
        #1;
        chk_idle_outputs("async_rst");
        idle_cycles(2);
        wb_rst     = 1'b0;
        gotRoom_in = 1'b1;
        chk("rst_no_strobe", strobe_cnt, 32'd0);

        // Asynchronous reset mid-write; the partial frame must be dropped.
        $display("txn reset during write");
        send_hdr(1'b0, 7'h02, 32'd4, 3);
        send_byte(8'h77);
        send_byte(8'h88);
        #2;
        wb_rst = 1'b1;
        #1;
        chk_idle_outputs("h2f_rst");
        idle_cycles(2);
        wb_rst = 1'b0;
        idle_cycles(1);
        do_read(7'h02, 1, 8'h00);
        do_read(7'h00, 1, 8'h00);
        do_read(7'h01, 2, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
